// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch SRAM-like to AXI read bridge: one AR in flight at a time,
// up to two reads outstanding, read data returned in issue order.
module inst_sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    // SRAM-like fetch port
    input  logic        inst_sram_en,
    input  logic        inst_sram_wr,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_wdata,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic [31:0] inst_sram_addr_ok_addr,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // Debug visibility of the AR FSM and the outstanding-read counter
    output logic        dbg_ar_busy,
    output logic [1:0]  dbg_outstanding
);

    // Handshake rule: a transfer happens on a rising edge where valid && ready;
    // the source holds valid and payload stable until that edge.

    typedef enum logic {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;

    ar_state_t   state, state_next;
    logic [1:0]  outstanding;
    logic        capture;
    logic        ar_hs;
    logic        r_hs;

    // Write controls and AXI response metadata carry no meaning for fetches.
    logic unused_ok;
    assign unused_ok = &{1'b0, inst_sram_wen, inst_sram_wdata, rid, rresp, rlast};

    assign arid    = 4'd0;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    assign rready                 = (outstanding != 2'd0);
    assign inst_sram_addr_ok      = ar_hs;
    assign inst_sram_addr_ok_addr = araddr;
    assign inst_sram_data_ok      = r_hs;
    assign inst_sram_rdata        = rdata;

    assign dbg_ar_busy     = (state == AR_BUSY);
    assign dbg_outstanding = outstanding;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            AR_IDLE: begin
                // Registered counter: a slot freed this cycle is usable next cycle.
                if (inst_sram_en && !inst_sram_wr && (outstanding < 2'd2)) begin
                    capture    = 1'b1;
                    state_next = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (ar_hs) begin
                    state_next = AR_IDLE;
                end
            end
            default: state_next = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= AR_IDLE;
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            arsize  <= 3'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                arvalid <= 1'b1;
                araddr  <= inst_sram_addr;
                arsize  <= {1'b0, inst_sram_size};
            end else if (ar_hs) begin
                arvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= 2'd0;
        end else if (ar_hs && !r_hs && (outstanding != 2'd2)) begin
            outstanding <= outstanding + 2'd1;
        end else if (r_hs && !ar_hs && (outstanding != 2'd0)) begin
            outstanding <= outstanding - 2'd1;
        end
    end

endmodule
